cfu_l2_arb2: RTL and testbench

- Two-initiator, one-target CFU-L2 arbiter that lets two requesters share one stateful streaming CFU, e.g. a single mulacc_l2_cfu.
- Round-robin grant on the request channel.
- An in-order tag FIFO routes each response back to the initiator that issued it, so pipelined targets (latency ≥ 1, several requests in flight) are supported.
- Sits between two CPU/CFU-L2 initiators and a mux1_cfu/mulacc composition.

---
 rtl/cfu_l2_arb2_pkg.sv | 27 ++
 rtl/cfu_tag_fifo.sv | 54 +++++
 rtl/cfu_l2_arb2.sv | 153 +++++++++++++++
 tb/tb_cfu_l2_arb2.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_l2_arb2_pkg.sv
// Shared CFU-L2 types, widths and parameter-check helpers for the two-initiator arbiter.
package cfu_l2_arb2_pkg;

  // Function identifier carried on every CFU-L2 request.
  typedef logic [9:0] cfid_t;

  localparam int CFU_STATUS_W = 3;

  typedef enum logic [CFU_STATUS_W-1:0] {
    CFU_OK         = 3'd0,
    CFU_ERR_CFU    = 3'd1,
    CFU_ERR_STATE  = 3'd2,
    CFU_ERR_FUNC   = 3'd3,
    CFU_ERR_OP     = 3'd4,
    CFU_ERR_CUSTOM = 3'd7
  } cfu_status_t;

  // Width of an id field that selects one of n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// In-order tag FIFO: remembers which initiator owns each request still in flight.
module cfu_tag_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd, wr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // Overflow/underflow are ignored rather than corrupting the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd];

  // Tag storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (clk_en && !rst && do_push) mem[wr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (rst) begin
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (do_push) wr <= wr + 1'b1;
        if (do_pop)  rd <= rd + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cfu_l2_arb2.sv
// Two-initiator round-robin CFU-L2 arbiter in front of one pipelined, stateful CFU.
// Requests pass straight through; a tag FIFO steers responses back in issue order.
module cfu_l2_arb2
  import cfu_l2_arb2_pkg::*;
#(
  parameter  int N_CFUS     = 1,
  parameter  int N_STATES   = 1,
  parameter  int FUNC_ID_W  = $bits(cfid_t),
  parameter  int INSN_W     = 0,
  parameter  int DATA_W     = 32,
  parameter  int MAX_OUT    = 4,
  localparam int CFU_ID_W   = id_w(N_CFUS),
  localparam int STATE_ID_W = id_w(N_STATES),
  // With INSN_W=0 the insn ports shrink to a single bit that integrators tie off.
  localparam int INSN_PW    = (INSN_W > 0) ? INSN_W : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  // initiator 0
  input  logic                    i0_req_valid,
  output logic                    i0_req_ready,
  input  logic [CFU_ID_W-1:0]     i0_req_cfu,
  input  logic [STATE_ID_W-1:0]   i0_req_state,
  input  logic [FUNC_ID_W-1:0]    i0_req_func,
  input  logic [INSN_PW-1:0]      i0_req_insn,
  input  logic [DATA_W-1:0]       i0_req_data0,
  input  logic [DATA_W-1:0]       i0_req_data1,
  output logic                    i0_resp_valid,
  input  logic                    i0_resp_ready,
  output logic [CFU_STATUS_W-1:0] i0_resp_status,
  output logic [DATA_W-1:0]       i0_resp_data,
  // initiator 1
  input  logic                    i1_req_valid,
  output logic                    i1_req_ready,
  input  logic [CFU_ID_W-1:0]     i1_req_cfu,
  input  logic [STATE_ID_W-1:0]   i1_req_state,
  input  logic [FUNC_ID_W-1:0]    i1_req_func,
  input  logic [INSN_PW-1:0]      i1_req_insn,
  input  logic [DATA_W-1:0]       i1_req_data0,
  input  logic [DATA_W-1:0]       i1_req_data1,
  output logic                    i1_resp_valid,
  input  logic                    i1_resp_ready,
  output logic [CFU_STATUS_W-1:0] i1_resp_status,
  output logic [DATA_W-1:0]       i1_resp_data,
  // target
  output logic                    t_req_valid,
  input  logic                    t_req_ready,
  output logic [CFU_ID_W-1:0]     t_req_cfu,
  output logic [STATE_ID_W-1:0]   t_req_state,
  output logic [FUNC_ID_W-1:0]    t_req_func,
  output logic [INSN_PW-1:0]      t_req_insn,
  output logic [DATA_W-1:0]       t_req_data0,
  output logic [DATA_W-1:0]       t_req_data1,
  input  logic                    t_resp_valid,
  output logic                    t_resp_ready,
  input  logic [CFU_STATUS_W-1:0] t_resp_status,
  input  logic [DATA_W-1:0]       t_resp_data
);

  // Parameter sanity, caught at elaboration.
  if (!is_pow2(MAX_OUT) || MAX_OUT < 2) begin : g_bad_max_out
    $error("cfu_l2_arb2: MAX_OUT must be a power of 2 and >= 2");
  end
  if (N_CFUS < 1 || N_STATES < 1 || FUNC_ID_W < 1 || DATA_W < 1 || INSN_W < 0) begin : g_bad_params
    $error("cfu_l2_arb2: illegal CFU-L2 port parameters");
  end

  typedef struct packed {
    logic [CFU_ID_W-1:0]   cfu;
    logic [STATE_ID_W-1:0] state;
    logic [FUNC_ID_W-1:0]  func;
    logic [INSN_PW-1:0]    insn;
    logic [DATA_W-1:0]     data0;
    logic [DATA_W-1:0]     data1;
  } req_t;

  req_t r0, r1, rw;
  logic prio, lock, lock_id, win, win_vld;
  logic full, empty, head, accept, pop;

  assign r0 = '{cfu: i0_req_cfu, state: i0_req_state, func: i0_req_func,
                insn: i0_req_insn, data0: i0_req_data0, data1: i0_req_data1};
  assign r1 = '{cfu: i1_req_cfu, state: i1_req_state, func: i1_req_func,
                insn: i1_req_insn, data0: i1_req_data0, data1: i1_req_data1};

  // Winner: a stalled grant stays put; otherwise lone requester, else round-robin priority.
  always_comb begin
    win = prio;
    if (lock)                               win = lock_id;
    else if (i0_req_valid && !i1_req_valid) win = 1'b0;
    else if (i1_req_valid && !i0_req_valid) win = 1'b1;
  end

  assign rw      = win ? r1 : r0;
  assign win_vld = win ? i1_req_valid : i0_req_valid;

  // Issue is gated on the registered FIFO level only, so there is no ready-through-pop path.
  assign t_req_valid  = !rst && win_vld && !full;
  assign i0_req_ready = !rst && !win && t_req_ready && !full;
  assign i1_req_ready = !rst &&  win && t_req_ready && !full;
  assign t_req_cfu    = rw.cfu;
  assign t_req_state  = rw.state;
  assign t_req_func   = rw.func;
  assign t_req_insn   = rw.insn;
  assign t_req_data0  = rw.data0;
  assign t_req_data1  = rw.data1;
  assign accept       = t_req_valid && t_req_ready && clk_en;

  // Grant state: flip priority on accept, latch the winner while the target back-pressures.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (rst) begin
        prio    <= 1'b0;
        lock    <= 1'b0;
        lock_id <= 1'b0;
      end else if (accept) begin
        prio <= ~win;
        lock <= 1'b0;
      end else if (t_req_valid) begin
        lock    <= 1'b1;
        lock_id <= win;
      end
    end
  end

  cfu_tag_fifo #(.WIDTH(1), .DEPTH(MAX_OUT)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .push   (accept),
    .din    (win),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty)
  );

  // Responses go to the FIFO head owner; payload is broadcast and qualified by valid.
  assign t_resp_ready   = !rst && !empty && (head ? i1_resp_ready : i0_resp_ready);
  assign i0_resp_valid  = !rst && !empty && !head && t_resp_valid;
  assign i1_resp_valid  = !rst && !empty &&  head && t_resp_valid;
  assign i0_resp_status = t_resp_status;
  assign i1_resp_status = t_resp_status;
  assign i0_resp_data   = t_resp_data;
  assign i1_resp_data   = t_resp_data;
  assign pop            = t_resp_valid && t_resp_ready && clk_en;

  // A response with nothing outstanding means the target broke protocol.
  a_resp_while_empty: assert property (@(posedge clk) disable iff (rst)
    !(clk_en && t_resp_valid && empty));

endmodule

// File: tb/tb_cfu_l2_arb2.sv
// Directed bench for cfu_l2_arb2 with a small latency-programmable multiply target model.
module tb_cfu_l2_arb2;
  import cfu_l2_arb2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1, clk_en = 1'b1;
  logic i0_req_valid = 0, i0_req_ready, i1_req_valid = 0, i1_req_ready;
  logic [0:0] i0_req_cfu = '0, i0_req_state = '0, i0_req_insn = '0;
  logic [0:0] i1_req_cfu = '0, i1_req_state = '0, i1_req_insn = '0;
  logic [9:0] i0_req_func = '0, i1_req_func = '0;
  logic [31:0] i0_req_data0 = 0, i0_req_data1 = 0, i1_req_data0 = 0, i1_req_data1 = 0;
  logic i0_resp_valid, i1_resp_valid, i0_resp_ready = 1, i1_resp_ready = 1;
  logic [CFU_STATUS_W-1:0] i0_resp_status, i1_resp_status, t_resp_status;
  logic [31:0] i0_resp_data, i1_resp_data, t_resp_data;
  logic t_req_valid, t_req_ready = 0, t_resp_valid, t_resp_ready;
  logic [0:0] t_req_cfu, t_req_state, t_req_insn;
  logic [9:0] t_req_func;
  logic [31:0] t_req_data0, t_req_data1;

  int n_checks = 0, n_err = 0;

  always #5 clk = ~clk;

  cfu_l2_arb2 dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i0_req_valid(i0_req_valid), .i0_req_ready(i0_req_ready), .i0_req_cfu(i0_req_cfu),
    .i0_req_state(i0_req_state), .i0_req_func(i0_req_func), .i0_req_insn(i0_req_insn),
    .i0_req_data0(i0_req_data0), .i0_req_data1(i0_req_data1),
    .i0_resp_valid(i0_resp_valid), .i0_resp_ready(i0_resp_ready),
    .i0_resp_status(i0_resp_status), .i0_resp_data(i0_resp_data),
    .i1_req_valid(i1_req_valid), .i1_req_ready(i1_req_ready), .i1_req_cfu(i1_req_cfu),
    .i1_req_state(i1_req_state), .i1_req_func(i1_req_func), .i1_req_insn(i1_req_insn),
    .i1_req_data0(i1_req_data0), .i1_req_data1(i1_req_data1),
    .i1_resp_valid(i1_resp_valid), .i1_resp_ready(i1_resp_ready),
    .i1_resp_status(i1_resp_status), .i1_resp_data(i1_resp_data),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_cfu(t_req_cfu),
    .t_req_state(t_req_state), .t_req_func(t_req_func), .t_req_insn(t_req_insn),
    .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
    .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
  );

  // Target model: returns data0*data1, each response `lat` cycles after its accept.
  logic [31:0] qd[$];
  int          qdue[$];
  int          cyc = 0, lat = 1, hdue = 0;
  bit          resp_hold = 0;
  logic        hv = 0;
  logic [31:0] hd = '0;
  int          gl[$], ord[$];
  logic [31:0] r0l[$], r1l[$];

  assign t_resp_valid  = hv && (cyc >= hdue) && !resp_hold;
  assign t_resp_data   = hd;
  assign t_resp_status = '0;

  always @(posedge clk) begin
    if (clk_en) begin
      if (rst) begin
        qd.delete();
        qdue.delete();
      end else begin
        if (t_resp_valid && t_resp_ready) begin
          void'(qd.pop_front());
          void'(qdue.pop_front());
        end
        if (t_req_valid && t_req_ready) begin
          qd.push_back(32'(t_req_data0 * t_req_data1));
          qdue.push_back(cyc + lat);
        end
        if (i0_req_valid && i0_req_ready) gl.push_back(0);
        if (i1_req_valid && i1_req_ready) gl.push_back(1);
        if (i0_resp_valid && i0_resp_ready) begin r0l.push_back(i0_resp_data); ord.push_back(0); end
        if (i1_resp_valid && i1_resp_ready) begin r1l.push_back(i1_resp_data); ord.push_back(1); end
      end
    end
    cyc <= cyc + 1;
    hv  <= (qd.size() > 0);
    if (qd.size() > 0) begin
      hd   <= qd[0];
      hdue <= qdue[0];
    end
  end

  task automatic clear_logs();
    gl.delete(); ord.delete(); r0l.delete(); r1l.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clk_en = 1; i0_req_valid = 0; i1_req_valid = 0; resp_hold = 0;
    @(negedge clk);
    rst = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; clk_en = 1; i0_req_valid = 1; i1_req_valid = 1; t_req_ready = 1;
    #1;
    n_checks++; if (t_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_t_req_valid: got %b exp 0", t_req_valid); end
    n_checks++; if ({i0_req_ready, i1_req_ready} !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b exp 00", {i0_req_ready, i1_req_ready}); end
    n_checks++; if ({t_resp_ready, i0_resp_valid, i1_resp_valid} !== 3'b000) begin n_err++; $display("FAIL rst_resp: got %b exp 000", {t_resp_ready, i0_resp_valid, i1_resp_valid}); end
    @(negedge clk);
    rst = 0; i0_req_valid = 0; i1_req_valid = 0;
    #1;
    n_checks++; if (dut.u_fifo.count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", dut.u_fifo.count); end
    n_checks++; if ({dut.prio, dut.lock} !== 2'b00) begin n_err++; $display("FAIL rst_prio_lock: got %b exp 00", {dut.prio, dut.lock}); end
    clear_logs();
  endtask

  task automatic test_single();
    lat = 1; t_req_ready = 1; i0_resp_ready = 1; i1_resp_ready = 1;
    @(negedge clk);
    i0_req_valid = 1; i0_req_func = '0; i0_req_data0 = 3; i0_req_data1 = 4;
    #1;
    n_checks++; if (t_req_valid !== 1'b1) begin n_err++; $display("FAIL single_t_req_valid: got %b exp 1", t_req_valid); end
    n_checks++; if (t_req_data0 !== 32'd3 || t_req_data1 !== 32'd4) begin n_err++; $display("FAIL single_payload: got %0d,%0d exp 3,4", t_req_data0, t_req_data1); end
    n_checks++; if ({i0_req_ready, i1_req_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b exp 10", {i0_req_ready, i1_req_ready}); end
    @(negedge clk);
    i0_req_valid = 0;
    #1;
    n_checks++; if (i0_resp_valid !== 1'b1 || i0_resp_data !== 32'd12) begin n_err++; $display("FAIL single_resp: got v=%b d=%0d exp v=1 d=12", i0_resp_valid, i0_resp_data); end
    n_checks++; if (i1_resp_valid !== 1'b0) begin n_err++; $display("FAIL single_i1_resp_valid: got %b exp 0", i1_resp_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (i0_resp_valid !== 1'b0 || r0l.size() != 1) begin n_err++; $display("FAIL single_drain: got v=%b n=%0d exp v=0 n=1", i0_resp_valid, r0l.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    lat = 1; t_req_ready = 1;
    @(negedge clk);
    i0_req_valid = 1; i0_req_data0 = 2; i0_req_data1 = 5;
    i1_req_valid = 1; i1_req_data0 = 7; i1_req_data1 = 3;
    repeat (8) @(negedge clk);
    i0_req_valid = 0; i1_req_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (gl.size() != 8) begin n_err++; $display("FAIL rr_accepts: got %0d exp 8", gl.size()); end
    for (int i = 0; i < 8 && i < gl.size(); i++) begin
      n_checks++; if (gl[i] != i % 2) begin n_err++; $display("FAIL rr_grant[%0d]: got i%0d exp i%0d", i, gl[i], i % 2); end
    end
    n_checks++; if (r0l.size() != 4 || r1l.size() != 4) begin n_err++; $display("FAIL rr_resp_count: got %0d/%0d exp 4/4", r0l.size(), r1l.size()); end
    if (r0l.size() > 0 && r1l.size() > 0) begin
      n_checks++; if (r0l[0] !== 32'd10 || r1l[0] !== 32'd21) begin n_err++; $display("FAIL rr_resp_data: got %0d/%0d exp 10/21", r0l[0], r1l[0]); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    lat = 1; t_req_ready = 1;
    // one i0 accept leaves priority with i1, so only the lock can keep i0 granted
    @(negedge clk);
    i0_req_valid = 1; i0_req_data0 = 1; i0_req_data1 = 1;
    @(negedge clk);
    i0_req_valid = 0;
    repeat (2) @(negedge clk);
    t_req_ready = 0; i0_req_valid = 1; i0_req_data0 = 5;
    #1;
    n_checks++; if (t_req_valid !== 1'b1 || t_req_data0 !== 32'd5) begin n_err++; $display("FAIL lock_first: got v=%b d=%0d exp v=1 d=5", t_req_valid, t_req_data0); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i1_req_valid = 1; i1_req_data0 = 9; i1_req_data1 = 1;
      #1;
      n_checks++; if (t_req_data0 !== 32'd5 || i1_req_ready !== 1'b0) begin n_err++; $display("FAIL lock_hold[%0d]: got d=%0d r1=%b exp d=5 r1=0", k, t_req_data0, i1_req_ready); end
    end
    @(negedge clk);
    t_req_ready = 1;
    #1;
    n_checks++; if ({i0_req_ready, i1_req_ready} !== 2'b10) begin n_err++; $display("FAIL lock_release: got %b exp 10", {i0_req_ready, i1_req_ready}); end
    @(negedge clk);
    i0_req_data0 = 6;
    #1;
    n_checks++; if ({i0_req_ready, i1_req_ready} !== 2'b01 || t_req_data0 !== 32'd9) begin n_err++; $display("FAIL lock_next_i1: got r=%b d=%0d exp r=01 d=9", {i0_req_ready, i1_req_ready}, t_req_data0); end
    @(negedge clk);
    i0_req_valid = 0; i1_req_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (gl.size() != 3) begin n_err++; $display("FAIL lock_accepts: got %0d exp 3", gl.size()); end
    if (gl.size() == 3) begin
      n_checks++; if (gl[1] != 0 || gl[2] != 1) begin n_err++; $display("FAIL lock_order: got i%0d,i%0d exp i0,i1", gl[1], gl[2]); end
    end
  endtask

  task automatic test_full();
    do_reset();
    lat = 1; t_req_ready = 1; resp_hold = 1;
    @(negedge clk);
    i0_req_valid = 1; i0_req_data0 = 2; i0_req_data1 = 2;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (t_req_valid !== 1'b0 || i0_req_ready !== 1'b0) begin n_err++; $display("FAIL full_stall: got v=%b r=%b exp 0 0", t_req_valid, i0_req_ready); end
    n_checks++; if (gl.size() != 4 || dut.u_fifo.count !== 3'd4) begin n_err++; $display("FAIL full_count: got acc=%0d cnt=%0d exp 4 4", gl.size(), dut.u_fifo.count); end
    resp_hold = 0;
    #1;
    n_checks++; if (i0_resp_valid !== 1'b1 || t_req_valid !== 1'b0) begin n_err++; $display("FAIL full_pop_cycle: got rv=%b tv=%b exp 1 0", i0_resp_valid, t_req_valid); end
    @(negedge clk);
    resp_hold = 1;
    #1;
    n_checks++; if (t_req_valid !== 1'b1 || i0_req_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got v=%b r=%b exp 1 1", t_req_valid, i0_req_ready); end
    @(negedge clk);
    i0_req_valid = 0;
    n_checks++; if (gl.size() != 5) begin n_err++; $display("FAIL full_fifth: got %0d exp 5", gl.size()); end
    resp_hold = 0;
    repeat (8) @(negedge clk);
    n_checks++; if (r0l.size() != 5) begin n_err++; $display("FAIL full_drain: got %0d exp 5", r0l.size()); end
  endtask

  task automatic test_in_order();
    int n;
    do_reset();
    lat = 3; t_req_ready = 1; i0_resp_ready = 1; i1_resp_ready = 0;
    @(negedge clk);
    i0_req_valid = 1; i0_req_data0 = 2; i0_req_data1 = 3;
    @(negedge clk);
    i0_req_valid = 0; i1_req_valid = 1; i1_req_data0 = 4; i1_req_data1 = 5;
    @(negedge clk);
    i1_req_valid = 0; i0_req_valid = 1; i0_req_data0 = 3; i0_req_data1 = 3;
    @(negedge clk);
    i0_req_valid = 0;
    n = 0;
    #1;
    while (!i1_resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    n_checks++; if (i1_resp_valid !== 1'b1) begin n_err++; $display("FAIL order_wait_i1: got %b exp 1 within 20 cycles", i1_resp_valid); end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (t_resp_ready !== 1'b0 || i0_resp_valid !== 1'b0 || i1_resp_data !== 32'd20) begin n_err++; $display("FAIL order_stall[%0d]: got tr=%b v0=%b d=%0d exp 0 0 20", k, t_resp_ready, i0_resp_valid, i1_resp_data); end
      if (k == 0) begin @(negedge clk); #1; end
    end
    @(negedge clk);
    i1_resp_ready = 1;
    #1;
    n_checks++; if (t_resp_ready !== 1'b1) begin n_err++; $display("FAIL order_unstall: got %b exp 1", t_resp_ready); end
    repeat (5) @(negedge clk);
    n_checks++; if (ord.size() != 3) begin n_err++; $display("FAIL order_count: got %0d exp 3", ord.size()); end
    if (ord.size() == 3 && r0l.size() == 2 && r1l.size() == 1) begin
      n_checks++; if (ord[0] != 0 || ord[1] != 1 || ord[2] != 0) begin n_err++; $display("FAIL order_seq: got %0d%0d%0d exp 010", ord[0], ord[1], ord[2]); end
      n_checks++; if (r0l[0] !== 32'd6 || r1l[0] !== 32'd20 || r0l[1] !== 32'd9) begin n_err++; $display("FAIL order_data: got %0d,%0d,%0d exp 6,20,9", r0l[0], r1l[0], r0l[1]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat = 3; t_req_ready = 1; i0_resp_ready = 1; i1_resp_ready = 1;
    @(negedge clk);
    i0_req_valid = 1; i0_req_data0 = 1; i0_req_data1 = 2;
    @(negedge clk);
    i0_req_valid = 0; i1_req_valid = 1; i1_req_data0 = 1; i1_req_data1 = 3;
    @(negedge clk);
    i1_req_valid = 0; i0_req_valid = 1; rst = 1;
    #1;
    n_checks++; if (dut.u_fifo.count !== 3'd2) begin n_err++; $display("FAIL mrst_inflight: got %0d exp 2", dut.u_fifo.count); end
    n_checks++; if ({t_req_valid, i0_req_ready, t_resp_ready, i0_resp_valid, i1_resp_valid} !== 5'b0) begin n_err++; $display("FAIL mrst_outputs: got %b exp 00000", {t_req_valid, i0_req_ready, t_resp_ready, i0_resp_valid, i1_resp_valid}); end
    @(negedge clk);
    rst = 0; i0_req_valid = 0;
    clear_logs();
    #1;
    n_checks++; if (dut.u_fifo.count !== 3'd0 || dut.prio !== 1'b0) begin n_err++; $display("FAIL mrst_state: got cnt=%0d prio=%b exp 0 0", dut.u_fifo.count, dut.prio); end
    @(negedge clk);
    i1_req_valid = 1; i1_req_data0 = 6; i1_req_data1 = 7;
    #1;
    n_checks++; if (i1_req_ready !== 1'b1 || t_req_valid !== 1'b1) begin n_err++; $display("FAIL mrst_post_req: got r=%b v=%b exp 1 1", i1_req_ready, t_req_valid); end
    @(negedge clk);
    i1_req_valid = 0;
    repeat (5) @(negedge clk);
    n_checks++; if (r1l.size() != 1 || r0l.size() != 0) begin n_err++; $display("FAIL mrst_resp_count: got %0d/%0d exp 0/1", r0l.size(), r1l.size()); end
    if (r1l.size() == 1) begin
      n_checks++; if (r1l[0] !== 32'd42) begin n_err++; $display("FAIL mrst_resp_data: got %0d exp 42", r1l[0]); end
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    lat = 1; t_req_ready = 1;
    @(negedge clk);
    clk_en = 0; i0_req_valid = 1; i0_req_data0 = 1; i0_req_data1 = 1;
    #1;
    n_checks++; if (t_req_valid !== 1'b1) begin n_err++; $display("FAIL clken_live: got %b exp 1", t_req_valid); end
    repeat (2) @(negedge clk);
    n_checks++; if (gl.size() != 0 || dut.u_fifo.count !== 3'd0) begin n_err++; $display("FAIL clken_frozen: got acc=%0d cnt=%0d exp 0 0", gl.size(), dut.u_fifo.count); end
    i0_req_valid = 0; clk_en = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_full();
    test_in_order();
    test_mid_reset();
    test_clk_en();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
